// File: rtl/rl_pair_scheduler_if.sv
// Pair bus between the scheduler and the range-limited force evaluation unit,
// plus the reference-load strobe seen by the cell position caches.
interface rl_pair_scheduler_if #(
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int NUM_FILTER        = 7
);
    logic [PARTICLE_ID_WIDTH-1:0] ref_particle_id;
    logic [PARTICLE_ID_WIDTH-1:0] nb_particle_id;
    logic [NUM_FILTER-1:0]        pair_valid;
    logic                         ref_load;
    logic [NUM_FILTER-1:0]        back_pressure;
    logic                         all_buffer_empty;

    modport master (
        output ref_particle_id,
        output nb_particle_id,
        output pair_valid,
        output ref_load,
        input  back_pressure,
        input  all_buffer_empty
    );

    modport slave (
        input  ref_particle_id,
        input  nb_particle_id,
        input  pair_valid,
        input  ref_load,
        output back_pressure,
        output all_buffer_empty
    );
endinterface

// File: rtl/rl_pair_scheduler.sv
// Walks every reference particle of a home cell, sweeps neighbor IDs over all
// filter lanes with per-lane back pressure, and drains the force unit between refs.
module rl_pair_scheduler #(
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int NUM_FILTER        = 7,
    parameter int DRAIN_MIN         = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [PARTICLE_ID_WIDTH-1:0]          num_ref_particles,
    input  logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0] nb_count,
    output logic                                  busy,
    output logic                                  done,
    rl_pair_scheduler_if.master                   pair_bus
);
    localparam int W   = PARTICLE_ID_WIDTH;
    localparam int CW  = W + 1;
    localparam int DCW = $clog2(DRAIN_MIN + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MIN - 1);

    typedef enum logic [1:0] {IDLE, LOAD_REF, SWEEP, DRAIN} state_t;

    state_t                state_reg, state_next;
    logic [W-1:0]          ref_id_reg, ref_id_next;
    logic [W-1:0]          nb_id_reg, nb_id_next;
    logic [NUM_FILTER-1:0] pair_valid_reg, pair_valid_next;
    logic                  ref_load_reg, ref_load_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic [W-1:0]          num_ref_reg, num_ref_next;
    logic [NUM_FILTER*W-1:0] nb_count_reg, nb_count_next;
    logic [W-1:0]          max_cnt_reg, max_cnt_next;
    logic [CW-1:0]         counter_reg, counter_next;
    logic [DCW-1:0]        drain_cnt_reg, drain_cnt_next;

    logic [W-1:0]          max_chain [NUM_FILTER+1];
    logic [NUM_FILTER-1:0] lane_hit;

    // Max over the incoming lane counts, folded lane by lane; only used at start.
    assign max_chain[0] = '0;
    generate
        for (genvar gi = 0; gi < NUM_FILTER; gi++) begin : g_lane
            assign max_chain[gi+1] = (nb_count[gi*W +: W] > max_chain[gi]) ?
                                     nb_count[gi*W +: W] : max_chain[gi];
            // Counter is one bit wider so the top ID compares without wrapping.
            assign lane_hit[gi] = (counter_reg <= {1'b0, nb_count_reg[gi*W +: W]});
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            ref_id_reg     <= '0;
            nb_id_reg      <= '0;
            pair_valid_reg <= '0;
            ref_load_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            num_ref_reg    <= '0;
            nb_count_reg   <= '0;
            max_cnt_reg    <= '0;
            counter_reg    <= '0;
            drain_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            ref_id_reg     <= ref_id_next;
            nb_id_reg      <= nb_id_next;
            pair_valid_reg <= pair_valid_next;
            ref_load_reg   <= ref_load_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            num_ref_reg    <= num_ref_next;
            nb_count_reg   <= nb_count_next;
            max_cnt_reg    <= max_cnt_next;
            counter_reg    <= counter_next;
            drain_cnt_reg  <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ref_id_next     = ref_id_reg;
        nb_id_next      = nb_id_reg;
        pair_valid_next = pair_valid_reg;
        ref_load_next   = 1'b0;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        num_ref_next    = num_ref_reg;
        nb_count_next   = nb_count_reg;
        max_cnt_next    = max_cnt_reg;
        counter_next    = counter_reg;
        drain_cnt_next  = drain_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    num_ref_next  = num_ref_particles;
                    nb_count_next = nb_count;
                    max_cnt_next  = max_chain[NUM_FILTER];
                    if (num_ref_particles == '0) begin
                        done_next = 1'b1;
                    end else begin
                        busy_next     = 1'b1;
                        ref_id_next   = W'(1);
                        ref_load_next = 1'b1;
                        state_next    = LOAD_REF;
                    end
                end
            end
            LOAD_REF: begin
                counter_next   = CW'(1);
                drain_cnt_next = '0;
                state_next     = (max_cnt_reg == '0) ? DRAIN : SWEEP;
            end
            SWEEP: begin
                // Stalled cycles hold the counter so no neighbor is skipped or repeated.
                if (|pair_bus.back_pressure) begin
                    pair_valid_next = '0;
                end else begin
                    nb_id_next      = counter_reg[W-1:0];
                    pair_valid_next = lane_hit;
                    counter_next    = counter_reg + CW'(1);
                    if (counter_reg == {1'b0, max_cnt_reg}) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                pair_valid_next = '0;
                if (drain_cnt_reg != DRAIN_LAST) begin
                    drain_cnt_next = drain_cnt_reg + DCW'(1);
                end else if (pair_bus.all_buffer_empty) begin
                    if (ref_id_reg == num_ref_reg) begin
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        ref_id_next   = ref_id_reg + W'(1);
                        ref_load_next = 1'b1;
                        state_next    = LOAD_REF;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pair_bus.ref_particle_id = ref_id_reg;
    assign pair_bus.nb_particle_id  = nb_id_reg;
    assign pair_bus.pair_valid      = pair_valid_reg;
    assign pair_bus.ref_load        = ref_load_reg;
    assign busy                     = busy_reg;
    assign done                     = done_reg;
endmodule
